// File: rtl/hamming_encoder_pkg.sv
// Shared Hamming(7,4) definitions: frame layout, codeword width and the parity
// equations, kept here so the receive-side decoder can reuse them unchanged.
package hamming_pkg;

   localparam int DATA_W   = 8;
   localparam int NIB_W    = 4;
   localparam int CW_W     = 7;
   localparam int SEQ_W    = 2;
   localparam int FRAME_W  = 2 * CW_W + SEQ_W;
   localparam int CNT_W    = 16;
   localparam int FIFO_CW  = 2;

   localparam int HI_MSB   = 15;
   localparam int HI_LSB   = HI_MSB - CW_W + 1;
   localparam int LO_MSB   = 8;
   localparam int LO_LSB   = LO_MSB - CW_W + 1;
   localparam int SEQ_MSB  = 1;

   localparam logic [FIFO_CW-1:0] FIFO_FULL     = 2'd2;
   localparam logic [CNT_W-1:0]   FRAME_CNT_MAX = '1;

   // Field order matches the wire format: hi codeword in [15:9], lo in [8:2], seq in [1:0].
   typedef struct packed {
      logic [CW_W-1:0]  hi;
      logic [CW_W-1:0]  lo;
      logic [SEQ_W-1:0] seq;
   } frame_t;

   function automatic logic [CW_W-1:0] hamming74_enc(input logic [NIB_W-1:0] nibble);
      logic [CW_W-1:0] c;
      c[6:3] = nibble;
      c[2]   = c[6] ^ c[5] ^ c[4];
      c[1]   = c[6] ^ c[5] ^ c[3];
      c[0]   = c[6] ^ c[4] ^ c[3];
      return c;
   endfunction

   function automatic frame_t pack_frame(input logic [DATA_W-1:0] data,
                                         input logic [SEQ_W-1:0]  seq);
      frame_t f;
      f.hi  = hamming74_enc(data[7:4]);
      f.lo  = hamming74_enc(data[3:0]);
      f.seq = seq;
      return f;
   endfunction

endpackage

// File: rtl/hamming_encoder_if.sv
// Byte-in / frame-out bus of the Hamming encoder. The environment side is the
// master modport, the encoder itself is the slave.
interface hamming_encoder_if;

   // Both streams use valid/ready: a transfer happens on a rising edge where
   // valid and ready are both high; once valid is raised the payload and valid
   // hold until that edge, and ready never depends combinationally on valid.
   logic [hamming_pkg::DATA_W-1:0]  data_in;
   logic                            data_valid;
   logic                            data_ready;
   logic [hamming_pkg::FRAME_W-1:0] code_out;
   logic                            code_valid;
   logic                            code_ready;

   modport master (
      output data_in,
      output data_valid,
      input  data_ready,
      input  code_out,
      input  code_valid,
      output code_ready
   );

   modport slave (
      input  data_in,
      input  data_valid,
      output data_ready,
      output code_out,
      output code_valid,
      input  code_ready
   );

endinterface

// File: rtl/hamming_encoder_fifo2_byte.sv
// Two-entry byte FIFO with registered count; pushes at full and pops at empty
// are ignored so the caller may drive push/pop freely.
module fifo2_byte
   import hamming_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               push_i,
   input  logic [DATA_W-1:0]  data_i,
   input  logic               pop_i,
   output logic [DATA_W-1:0]  head_o,
   output logic [FIFO_CW-1:0] count_o
);

   logic [DATA_W-1:0]  mem_q [2];
   logic               rd_ptr_q, rd_ptr_d;
   logic               wr_ptr_q, wr_ptr_d;
   logic [FIFO_CW-1:0] count_q, count_d;
   logic               push_en;
   logic               pop_en;

   assign push_en = push_i && (count_q != FIFO_FULL);
   assign pop_en  = pop_i && (count_q != '0);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push_en) wr_ptr_d = ~wr_ptr_q;
      if (pop_en)  rd_ptr_d = ~rd_ptr_q;
      case ({push_en, pop_en})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         if (push_en) mem_q[wr_ptr_q] <= data_i;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/hamming_encoder.sv
// Hamming(7,4) transmit encoder: buffers bytes in a 2-deep FIFO and emits one
// registered 16-bit frame (two codewords plus a rolling sequence number) per byte.
module hamming_encoder
   import hamming_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 encode_enable,
   hamming_encoder_if.slave     bus,
   output logic [CNT_W-1:0]     frame_count
);

   logic [FIFO_CW-1:0] fifo_count;
   logic [DATA_W-1:0]  fifo_head;
   logic               data_ready;
   logic               push;
   logic               load;

   frame_t             code_out_q, code_out_d;
   logic               code_valid_q, code_valid_d;
   logic [SEQ_W-1:0]   seq_q, seq_d;
   logic [CNT_W-1:0]   frame_count_q, frame_count_d;

   // Ready comes only from the registered count, never from the output side.
   assign data_ready = (fifo_count != FIFO_FULL);
   assign push       = bus.data_valid && data_ready;
   assign load       = encode_enable && (fifo_count != '0) &&
                       (!code_valid_q || bus.code_ready);

   fifo2_byte u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .data_i  (bus.data_in),
      .pop_i   (load),
      .head_o  (fifo_head),
      .count_o (fifo_count)
   );

   always_comb begin
      code_out_d    = code_out_q;
      code_valid_d  = code_valid_q;
      seq_d         = seq_q;
      frame_count_d = frame_count_q;
      if (load) begin
         code_out_d   = pack_frame(fifo_head, seq_q);
         code_valid_d = 1'b1;
         seq_d        = seq_q + 2'd1;
         if (frame_count_q != FRAME_CNT_MAX) frame_count_d = frame_count_q + 16'd1;
      end else if (code_valid_q && bus.code_ready) begin
         code_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         code_out_q    <= '0;
         code_valid_q  <= 1'b0;
         seq_q         <= '0;
         frame_count_q <= '0;
      end else begin
         code_out_q    <= code_out_d;
         code_valid_q  <= code_valid_d;
         seq_q         <= seq_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign bus.data_ready = data_ready;
   assign bus.code_out   = code_out_q;
   assign bus.code_valid = code_valid_q;
   assign frame_count    = frame_count_q;

endmodule

// File: doc/hamming_encoder.md
# hamming_encoder

Transmit-side Hamming(7,4) encoder and frame packer feeding the receive-path decoder. It accepts bytes over a valid/ready handshake and buffers them in a 2-entry FIFO. Each byte is encoded as two 7-bit codewords, which are packed into the 16-bit frame format the decoder consumes. The two spare frame bits carry a 2-bit rolling sequence number for link debugging; the decoder ignores them.

## Interface
- No parameters; frame format is fixed.
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- encode_enable  in  1  1 = frames may be produced; 0 = output stage holds and the FIFO still fills
- data_in  in  8  byte to encode
- data_valid  in  1  data_in is valid
- data_ready  out  1  FIFO can take a byte; equals (fifo_count != 2)
- code_out  out  16  frame: [15:9] codeword of data[7:4], [8:2] codeword of data[3:0], [1:0] sequence number
- code_valid  out  1  code_out holds an unconsumed frame
- code_ready  in  1  downstream accepts code_out this cycle
- frame_count  out  16  frames emitted since reset; saturates at 0xFFFF

## Operation
- Codeword bit mapping for nibble d[3:0]: c[6:3]=d[3:0], c2=c6^c5^c4, c1=c6^c5^c3, c0=c6^c4^c3. A clean frame therefore gives the decoder syndrome 000.
- Input push: occurs when data_valid && data_ready at a rising edge; the byte is written at the FIFO tail.
- data_ready: depends only on the registered count. There is no combinational path from code_ready or data_valid.
- Load condition: encode_enable && fifo_count!=0 && (!code_valid || code_ready).
- When the load condition holds:
  - pop the FIFO head
  - register code_out = {enc(head[7:4]), enc(head[3:0]), seq}
  - set code_valid=1
  - seq increments mod 4 (3 wraps to 0)
  - frame_count increments unless already 0xFFFF
- Output accept: code_valid && code_ready with no load → code_valid=0. code_out keeps its last value.
- Hold: while code_valid && !code_ready, code_out is stable. Data may not change until the frame is accepted.
- Simultaneous push and pop: allowed at any count, including a push at count 1 together with a pop. A push is only accepted when count<2, so a push at count 2 never happens.
- encode_enable=0:
  - no new loads
  - a frame already presented stays valid until accepted
  - pushes continue until the FIFO is full
- Reset mid-operation: FIFO contents, the pending frame, seq and frame_count are discarded immediately.

## Timing
- Reset values: code_out=0x0000, code_valid=0, frame_count=0, seq=0, fifo_count=0. data_ready=1 while reset is held and after it.
- Latency:
  - byte accepted at edge k into an empty FIFO with the output stage idle → code_valid=1 after edge k+1
  - minimum latency is 2 edges from push to frame visible
- Throughput: one frame per cycle sustained while code_ready=1, encode_enable=1 and data_valid=1.
- Back-pressure: with code_ready held low, at most 3 bytes are held (1 frame + 2 FIFO). data_ready drops after the 3rd accepted byte.

## Structure
- Shared package hamming_pkg:
  - constant CW_W=7 and frame field positions (HI_MSB=15, LO_MSB=8, SEQ_MSB=1)
  - function hamming74_enc(nibble) returning the 7-bit codeword
  - place the function here so a decoder rewrite can reuse the same parity equations
- Sub-module fifo2_byte: 2-entry, 8-bit FIFO with push, pop, count[1:0], head, async reset. The top level keeps seq, frame_count and the output register.

## Test plan
- Encode values:
  - after reset, push 0xA5 with code_ready=1 → code_out=0xA4B4, code_valid high for 1 cycle, frame_count=1
  - push 0x00 → 0x0001
  - push 0xFF → 0xFFFE
- Sequence wrap: push 5 consecutive bytes of 0x00 → code_out[1:0] = 0,1,2,3,0 and frame_count=5.
- Back-pressure:
  - code_ready=0, push 0x11, 0x22, 0x33 → data_ready=0 after the 3rd push; code_out stable with 0x11's frame
  - release code_ready → frames appear in order 0x11, 0x22, 0x33 on consecutive cycles
- Enable gating:
  - encode_enable=0, push 2 bytes → code_valid stays 0, data_ready=0
  - set encode_enable=1 → both frames emerge on consecutive cycles
- Reset mid-stream: assert reset with 2 bytes buffered and a frame pending → code_valid=0, code_out=0, data_ready=1 immediately; no stale frames after release.
- Loopback: feed code_out into the decoder and flip one bit per codeword in [15:2] → recovered byte equals the original for all 256 values.
